// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: registered N-way word selector with ready/valid on both sides.
// A beat carries the selected word, its select index and an illegal-select
// flag. An output register plus one skid register absorb up to two beats of
// downstream stall while keeping one-beat-per-cycle throughput.
module pipe_sel_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // One extra bit so NUM_IN itself is representable (e.g. NUM_IN=4, SEL_W=2).
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;

  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_err;
  logic             skid_valid;

  logic             accept;
  logic             release_beat;

  // Word selection: an out-of-range index selects nothing and yields zero.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
      end
    end
    sel_err = ({1'b0, in_sel} >= NUM_IN_W);
  end

  // The skid register is the only thing that can block the input side, so
  // ready is simply "skid empty", which is itself a register output.
  assign in_ready     = !skid_valid;
  assign accept       = in_valid && in_ready;
  assign release_beat = out_valid && out_ready;

  // Output stage and skid register update, in priority order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_err   <= 1'b0;
    end else if (release_beat) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_sel    <= skid_sel;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data <= sel_word;
        out_sel  <= in_sel;
        out_err  <= sel_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_data  <= sel_word;
        out_sel   <= in_sel;
        out_err   <= sel_err;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= sel_word;
        skid_sel   <= in_sel;
        skid_err   <= sel_err;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed bench for pipe_sel_mux: sweep, illegal select (3-input instance),
// backpressure, randomised handshake scoreboard and asynchronous reset.
module tb_pipe_sel_mux;

  logic         clk;
  logic         rst;

  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_err3;
  logic         out_valid3;
  logic         out_ready3;

  int n_checks;
  int n_fail;

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w [4];
  logic [33:0] q [$];
  logic [33:0] exp_beat;
  logic [31:0] held_data;
  logic        held;
  int          sent;
  int          cyc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data3 = '0; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_sel", {62'd0, out_sel}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

    // Sweep sel 0..3 with out_ready high
    in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      tick();
      chk("sweep_valid", {63'd0, out_valid}, 64'd1);
      chk("sweep_data", {32'd0, out_data}, {32'd0, {4{8'h11 * 8'(s + 1)}}});
      chk("sweep_sel", {62'd0, out_sel}, 64'(s));
      chk("sweep_err", {63'd0, out_err}, 64'd0);
      chk("sweep_in_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_drain_valid", {63'd0, out_valid}, 64'd0);
    chk("sweep_hold_data", {32'd0, out_data}, 64'h44444444);

    // Illegal select on the 3-input instance
    in_data3  = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    in_sel3   = 2'd3;
    in_valid3 = 1'b1;
    tick();
    chk("ill_valid", {63'd0, out_valid3}, 64'd1);
    chk("ill_data", {32'd0, out_data3}, 64'd0);
    chk("ill_sel", {62'd0, out_sel3}, 64'd3);
    chk("ill_err", {63'd0, out_err3}, 64'd1);
    in_sel3 = 2'd1;
    tick();
    chk("leg_data", {32'd0, out_data3}, 64'hBBBB0002);
    chk("leg_sel", {62'd0, out_sel3}, 64'd1);
    chk("leg_err", {63'd0, out_err3}, 64'd0);
    in_valid3 = 1'b0;
    tick();
    chk("ill_drain", {63'd0, out_valid3}, 64'd0);

    // Backpressure: A, B, C offered with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    chk("bp_a_out", {32'd0, out_data}, 64'h11111111);
    chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
    in_sel = 2'd1;
    tick();
    chk("bp_b_hold", {32'd0, out_data}, 64'h11111111);
    chk("bp_b_ready", {63'd0, in_ready}, 64'd0);
    in_sel = 2'd2;
    in_data[31:0] = 32'hDEADBEEF;
    tick();
    chk("bp_c_hold", {32'd0, out_data}, 64'h11111111);
    chk("bp_c_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_c_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_b", {32'd0, out_data}, 64'h22222222);
    chk("bp_rel_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp_rel_c", {32'd0, out_data}, 64'h33333333);
    chk("bp_rel_c_sel", {62'd0, out_sel}, 64'd2);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Random handshake with scoreboard
    sent = 0;
    cyc  = 0;
    while (cyc < 3000 && !(sent == 100 && q.size() == 0)) begin
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      in_data   = {w[3], w[2], w[1], w[0]};
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = (sent < 100) && ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      if (q.size() > 0) begin
        exp_beat = q[0];
        chk("rnd_data", {30'd0, out_sel, out_data}, {30'd0, exp_beat});
      end
      held      = (q.size() > 0) && !out_ready;
      held_data = out_data;
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        q.push_back({in_sel, w[in_sel]});
        sent++;
      end
      tick();
      if (held) chk("rnd_hold", {32'd0, out_data}, {32'd0, held_data});
      cyc++;
    end
    chk("rnd_complete", {32'd0, 32'(sent), 32'(q.size())}, {32'd0, 32'd100, 32'd0});

    // Asynchronous reset with both stages full
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_sel    = 2'd3;
    tick();
    tick();
    chk("ar_full_ready", {63'd0, in_ready}, 64'd0);
    chk("ar_full_valid", {63'd0, out_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid_now", {63'd0, out_valid}, 64'd0);
    chk("ar_ready_now", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    chk("ar_no_stale", {63'd0, out_valid}, 64'd0);
    chk("ar_ready_after", {63'd0, in_ready}, 64'd1);
    in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_sel   = 2'd2;
    in_valid = 1'b1;
    tick();
    chk("ar_new_beat", {32'd0, out_data}, 64'h33333333);
    in_valid = 1'b0;
    tick();
    chk("ar_new_drain", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_sel_mux.md
Name: pipe_sel_mux

Overview:
- Parametrised, registered N-way word selector with a ready/valid handshake on both sides.
- Each accepted beat captures the addressed input word, together with its select index and an illegal-select flag, into a 1-cycle output stage.
- A 2-entry skid structure (output register plus skid register) sustains full throughput under downstream backpressure.
- Intended for pipeline-stage operand and writeback selection where the source set grows beyond two and selection must be registered.

Parameters:
- WIDTH, 32: bits per input word and per output word.
- NUM_IN, 4: number of selectable inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN): select width. Derived; must not be overridden.

Ports:
- clk  input  1: rising-edge clock.
- rst  input  1: asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH: input words, flattened; word i = in_data[i*WIDTH +: WIDTH].
- in_sel  input  SEL_W: index of the word to capture.
- in_valid  input  1: upstream beat present.
- in_ready  output  1: block can accept a beat this cycle.
- out_data  output  WIDTH: selected word.
- out_sel  output  SEL_W: select index captured with the beat.
- out_err  output  1: beat carried an illegal select.
- out_valid  output  1: output beat present.
- out_ready  input  1: downstream accepts the beat.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values while rst=1 and on its release: out_valid=0, out_data=0, out_sel=0, out_err=0, skid register empty, in_ready=1.
- Accept: an input beat is accepted on any rising edge where in_valid && in_ready.
- Release: an output beat is released on any rising edge where out_valid && out_ready.
- Selection: word = in_data[in_sel*WIDTH +: WIDTH].
  - If in_sel >= NUM_IN, the captured word is all zeros and out_err=1 for that beat.
  - Otherwise out_err=0.
  - in_sel is captured unmodified into out_sel in both cases.
- Latency: a beat accepted on edge k appears with out_valid=1 after edge k when the output stage is empty, or is releasing on edge k.
- Output register update on each edge, in priority order:
  - (a) Release with skid full: output <- skid; skid emptied.
  - (b) Release with skid empty and an accept: output <- new beat.
  - (c) Release, no skid, no accept: out_valid <- 0; data fields hold their last value.
  - (d) No release, output empty, accept: output <- new beat.
  - (e) No release, output full, accept: skid <- new beat.
- in_ready is a registered signal equal to "skid empty after this edge". It must not depend combinationally on out_ready or in_valid.
- Hold rule: while out_valid=1 && out_ready=0, out_data, out_sel and out_err hold stable.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped.
- Throughput: one beat per cycle when out_ready is held at 1.
- Capacity: the maximum stall absorption is 2 beats. With skid full, in_ready=0 and in_valid is ignored.
- Unaccepted beats: in_data and in_sel are sampled only on accept edges; changes on any other cycle have no effect.
- Reset mid-operation: both stages are cleared immediately (asynchronously) and in-flight beats are discarded. in_ready=1 on the first edge after release.
- out_valid=0 data: out_data/out_sel/out_err are don't-care for the consumer but must still follow the hold-last-value rule (no X after reset).

Test Plan:
- Sweep: reset, then for NUM_IN=4, WIDTH=32, inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel=0..3 on consecutive cycles with out_ready=1 -> out_data 0x11111111..0x44444444 on 4 consecutive cycles, each 1 cycle after its accept; in_ready stays 1; out_err=0.
- Illegal select: NUM_IN=3, sel=3 -> out_data=0, out_sel=3, out_err=1. A following legal sel=1 beat -> out_err=0.
- Backpressure: out_ready=0, 3 beats offered back-to-back (A, B, C).
  - Required: A held on the output; B held in skid; in_ready=0 from the cycle after B is accepted; C not accepted.
  - Then raise out_ready: release order A, B, C with no loss; in_ready returns to 1 the cycle after B moves to the output.
- Simultaneous release and accept, skid empty, 100 random beats with in_valid and out_ready toggled randomly -> scoreboard confirms in-order, lossless transfer, and no out_data change while a stalled beat is held.
- Async reset with both stages full: assert rst between clock edges -> out_valid=0 and in_ready=1 immediately, without waiting for an edge; no stale beat appears after release.
